// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised shift/rotate/load register with multi-step burst mode (busy/done). Ports: clk, rst, en, mode[2:0], sin_l, sin_r, pdata, start, shamt -> out, sout_l, sout_r, busy, done; par when SHREG_PARITY_EN is defined.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = 8'hB4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
`ifdef SHREG_PARITY_EN
  output logic             par,
`endif
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] bmode;
  logic [CNT_W-1:0] cnt;
  logic go, stp;
  logic [2:0] op;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    go  = state == IDLE && start && mode != 3'd0 && mode < 3'd6;
    stp = en && !go;
    op  = state == BUSY ? bmode : mode;
    nxt = !stp          ? out :
          op == 3'd1    ? {sin_r, out[WIDTH-1:1]} :
          op == 3'd2    ? {out[WIDTH-2:0], sin_l} :
          op == 3'd3    ? {out[0], out[WIDTH-1:1]} :
          op == 3'd4    ? {out[WIDTH-2:0], out[WIDTH-1]} :
          op == 3'd5    ? {out[WIDTH-1], out[WIDTH-1:1]} :
          op == 3'd6    ? pdata : out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= RST_VAL;
      state <= IDLE;
      bmode <= 3'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      out  <= nxt;
      done <= 1'b0;
      if (go) begin
        bmode <= mode;
        cnt   <= shamt;
        state <= shamt == '0 ? IDLE : BUSY;
        done  <= shamt == '0;
      end else if (state == BUSY && en) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
`ifdef SHREG_PARITY_EN
  always_ff @(posedge clk) par <= rst ? ^RST_VAL : ^nxt;
`endif
  assign busy   = state == BUSY;
  assign sout_l = out[WIDTH-1];
  assign sout_r = out[0];
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed vector table plus hand sequences for universal_shift_register.
module tb_universal_shift_register;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, sin_l = 1'b0, sin_r = 1'b0, start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] pdata = 8'h00;
  logic [3:0] shamt = 4'd0;
  logic [7:0] out;
  logic sout_l, sout_r, busy, done;
`ifdef SHREG_PARITY_EN
  logic par;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  universal_shift_register dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdata(pdata), .start(start), .shamt(shamt),
`ifdef SHREG_PARITY_EN
    .par(par),
`endif
    .out(out), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );
  typedef struct {
    logic r, e; logic [2:0] m; logic sl, sr; logic [7:0] pd; logic st; logic [3:0] sa;
    logic [7:0] eo; logic eb, ed;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic sl, logic sr, logic [7:0] pd,
                              logic st, logic [3:0] sa, logic [7:0] eo, logic eb, logic ed);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.sl = sl; v.sr = sr; v.pd = pd; v.st = st; v.sa = sa;
    v.eo = eo; v.eb = eb; v.ed = ed;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step(vec_t v, string tag);
    rst = v.r; en = v.e; mode = v.m; sin_l = v.sl; sin_r = v.sr; pdata = v.pd; start = v.st; shamt = v.sa;
    @(posedge clk); #1;
    check({tag, " out"}, 32'(out), 32'(v.eo));
    check({tag, " busy"}, 32'(busy), 32'(v.eb));
    check({tag, " done"}, 32'(done), 32'(v.ed));
`ifdef SHREG_PARITY_EN
    check({tag, " par"}, 32'(par), 32'(^v.eo));
`endif
  endtask
  initial begin
    int n;
    vq.push_back(mk(1,0,3'd0,0,0,8'h00,0,4'd0, 8'hB4,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h96,0,4'd0, 8'h96,0,0));
    vq.push_back(mk(0,1,3'd1,0,1,8'h00,0,4'd0, 8'hCB,0,0));
    vq.push_back(mk(0,0,3'd1,0,1,8'h00,0,4'd0, 8'hCB,0,0));
    vq.push_back(mk(0,0,3'd1,0,1,8'h00,0,4'd0, 8'hCB,0,0));
    vq.push_back(mk(0,0,3'd1,0,1,8'h00,0,4'd0, 8'hCB,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h80,0,4'd0, 8'h80,0,0));
    vq.push_back(mk(0,1,3'd5,0,0,8'h00,0,4'd0, 8'hC0,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h81,0,4'd0, 8'h81,0,0));
    vq.push_back(mk(0,1,3'd4,0,0,8'h00,0,4'd0, 8'h03,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h81,0,4'd0, 8'h81,0,0));
    vq.push_back(mk(0,1,3'd3,0,0,8'h00,0,4'd0, 8'hC0,0,0));
    vq.push_back(mk(0,1,3'd2,1,0,8'h00,0,4'd0, 8'h81,0,0));
    vq.push_back(mk(0,1,3'd7,0,0,8'h00,0,4'd0, 8'h81,0,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h81,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h55,1,4'd3, 8'h55,0,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'h01,0,4'd0, 8'h01,0,0));
    vq.push_back(mk(0,1,3'd4,0,0,8'h00,1,4'd3, 8'h01,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h02,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h04,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h08,0,1));
    vq.push_back(mk(0,0,3'd0,0,0,8'h00,0,4'd0, 8'h08,0,0));
    vq.push_back(mk(0,1,3'd4,0,0,8'h00,1,4'd3, 8'h08,1,0));
    vq.push_back(mk(0,1,3'd6,0,0,8'hFF,0,4'd0, 8'h10,1,0));
    vq.push_back(mk(0,0,3'd0,0,0,8'h00,0,4'd0, 8'h10,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h20,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h40,0,1));
    vq.push_back(mk(0,1,3'd1,0,1,8'h00,1,4'd0, 8'h40,0,1));
    vq.push_back(mk(0,0,3'd0,0,0,8'h00,0,4'd0, 8'h40,0,0));
    vq.push_back(mk(0,1,3'd4,0,0,8'h00,1,4'd3, 8'h40,1,0));
    vq.push_back(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h80,1,0));
    vq.push_back(mk(1,1,3'd0,0,0,8'h00,0,4'd0, 8'hB4,0,0));
    vq.push_back(mk(0,0,3'd0,0,0,8'h00,0,4'd0, 8'hB4,0,0));
    foreach (vq[i]) begin
      step(vq[i], $sformatf("v%0d", i));
      if (i == 0) begin
        check("reset sout_l", 32'(sout_l), 32'd1);
        check("reset sout_r", 32'(sout_r), 32'd0);
      end
    end
    step(mk(0,1,3'd6,0,0,8'h01,0,4'd0, 8'h01,0,0), "b2b load");
    step(mk(0,1,3'd4,0,0,8'h00,1,4'd1, 8'h01,1,0), "b2b start1");
    step(mk(0,1,3'd4,0,0,8'h00,1,4'd2, 8'h02,0,1), "b2b end1");
    step(mk(0,1,3'd4,0,0,8'h00,1,4'd2, 8'h02,1,0), "b2b start2");
    step(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h04,1,0), "b2b mid2");
    step(mk(0,1,3'd0,0,0,8'h00,0,4'd0, 8'h08,0,1), "b2b end2");
    step(mk(0,1,3'd6,0,0,8'hFF,0,4'd0, 8'hFF,0,0), "flush load");
    step(mk(0,1,3'd2,0,0,8'h00,1,4'd9, 8'hFF,1,0), "flush start");
    start = 1'b0;
    n = 0;
    while (!done && n < 15) begin
      @(posedge clk); #1;
      n++;
    end
    check("flush steps", 32'(n), 32'd9);
    check("flush out", 32'(out), 32'h00);
    check("flush busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register and successor to the fixed 4-bit right shifter.
- Supports hold, logical shift left/right with serial inputs, rotate left/right, arithmetic right shift, and parallel load.
- Adds a multi-step burst mode: one start pulse shifts or rotates by a programmable amount, with busy/done handshake.
- Serves as a datapath building block for serializers, CRC/LFSR front-ends and barrel-shift replacements in low-area designs.

Parameters:
WIDTH, 8, register width in bits; WIDTH >= 2.
RST_VAL, 8'hB4, value loaded into out on reset; WIDTH bits wide.
CNT_W, $clog2(WIDTH+1), width of shamt; derived, not to be overridden.

Ports:
clk  input  1  clock; all state updates on posedge clk.
rst  input  1  reset, synchronous, active-high.
en  input  1  step enable; gates single-step ops and every burst step.
mode  input  3  operation select (encoding below).
sin_l  input  1  serial bit entering at LSB on shift left.
sin_r  input  1  serial bit entering at MSB on shift right.
pdata  input  WIDTH  parallel load data.
start  input  1  burst request, sampled in IDLE only.
shamt  input  CNT_W  burst step count, sampled with start.
out  output  WIDTH  register contents.
sout_l  output  1  out[WIDTH-1], combinational from the register.
sout_r  output  1  out[0], combinational from the register.
busy  output  1  high while in BUSY.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at posedge): out=RST_VAL, state=IDLE, busy=0, done=0, step counter=0. Reset has priority over all other inputs, including mid-burst; an aborted burst produces no done.
- mode encoding, one step:
  - 000 hold.
  - 001 SHR: {sin_r, out[W-1:1]}.
  - 010 SHL: {out[W-2:0], sin_l}.
  - 011 ROR: {out[0], out[W-1:1]}.
  - 100 ROL: {out[W-2:0], out[W-1]}.
  - 101 ASR: {out[W-1], out[W-1:1]}.
  - 110 LOAD: pdata.
  - 111 reserved, behaves as hold.
- FSM states: IDLE, BUSY.
- IDLE, start=1, mode in {001..101}:
  - Latch mode into an internal burst-mode register; latch shamt into the counter.
  - If shamt=0: no shift, stay IDLE, done=1 next cycle.
  - Otherwise: go BUSY next cycle; no shift occurs in the start cycle.
- IDLE, start=1, mode not a shift/rotate mode: start is ignored, and the cycle behaves as a single step.
- IDLE, start=0, en=1: single step per mode; latency 1 cycle (new out visible after the edge).
- IDLE, en=0 and start=0: hold.
- BUSY, each cycle:
  - en=1: perform one step with the latched mode and decrement the counter.
  - en=0: stall; out and counter hold.
- BUSY exit: when the counter is 1 and en=1, perform the final step and return to IDLE. done=1 in the following cycle, coincident with the final out value.
- In BUSY, mode, pdata, start and shamt are ignored. sin_l/sin_r are sampled live on every step.
- busy = (state==BUSY); it is registered and deasserts in the same cycle done asserts.
- done is high for exactly one cycle. A new start is accepted in the cycle done is high (back-to-back bursts allowed).
- shamt is used literally, including values >= WIDTH: logical shifts fully flush; rotates wrap modulo WIDTH by repetition.

Optional Feature:
Macro SHREG_PARITY_EN.
- Defined: adds output port par (1 bit), a register updated in lockstep with out so that par == ^out after every edge. On reset, par = ^RST_VAL.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with WIDTH=8, RST_VAL=8'hB4 -> out=8'hB4, sout_l=1, sout_r=0, busy=0, done=0.
- mode=110, pdata=8'h96, en=1 -> out=8'h96. Then mode=001, sin_r=1 -> out=8'hCB. Then en=0 for 3 cycles -> out stays 8'hCB.
- Load 8'h80, then mode=101 -> 8'hC0. Load 8'h81, then mode=100 -> 8'h03. Load 8'h81, then mode=011 -> 8'hC0.
- Burst: out=8'h01, mode=100, shamt=3, start pulse, en=1 -> busy for 3 cycles, out 02,04,08, then done=1 for one cycle with out=08. Repeat with en=0 for one mid-burst cycle -> busy lasts 4 cycles, same final 08.
- start with shamt=0 -> out unchanged, busy stays 0, done=1 next cycle. Separately, rst=1 in the 2nd BUSY cycle -> out=8'hB4, busy=0, no done pulse.
- With SHREG_PARITY_EN defined: reset -> par=0 (B4 has four ones). Load 8'h96 -> par=0. SHR with sin_r=1 -> out=CB, par=1.
